ccp_tag_bank_ctrl: RTL and testbench
====================================

Name: ccp_tag_bank_ctrl

Overview:
Initiator/controller side of the banked CCP tag memory. It drives the tag SRAM bank interface: chip enable, write enable, per-way write mask, address and data_in. It reads back tag_mem_data_out and returns tag lookup results. After reset it clears every set of every bank, then serves one lookup or write request per cycle, with a fixed 2-cycle read response.

Parameters:
N_SETS, 1024, total sets across all banks
N_TAG_BANKS, 2, tag banks (power of 2)
N_WAYS, 2, ways per set
TAG_PER_WAY_DATA_W, 25, bits per way entry: MSB = valid, [TAG_W-1:0] = tag
SET_W, $clog2(N_SETS), derived
BNK_W, $clog2(N_TAG_BANKS), derived (0 when N_TAG_BANKS=1)
SET_PER_BANK, N_SETS/N_TAG_BANKS, derived
SET_PER_BANK_W, $clog2(SET_PER_BANK), derived
TAG_W, TAG_PER_WAY_DATA_W-1, derived

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
init_done  out  1  high once the clear sweep is complete
req_valid  in  1  request valid
req_ready  out  1  equals init_done
req_write  in  1  1 = write, 0 = lookup
req_set  in  SET_W  set index; bank = req_set[BNK_W-1:0], bank address = req_set[SET_W-1:BNK_W]
req_tag  in  TAG_W  lookup tag
req_way_mask  in  N_WAYS  write way mask
req_wdata  in  N_WAYS*TAG_PER_WAY_DATA_W  write data, way i at slice i
rsp_valid  out  1  lookup result valid (single-cycle pulse)
rsp_set  out  SET_W  set of the response
rsp_hit  out  1  any way valid with matching tag
rsp_hit_way_oh  out  N_WAYS  per-way match vector
rsp_multi_hit  out  1  more than one way matched (error)
rsp_rdata  out  N_WAYS*TAG_PER_WAY_DATA_W  raw set data read
tag_mem_chip_en  out  N_TAG_BANKS  per-bank enable
tag_mem_write_en  out  N_TAG_BANKS  per-bank write
tag_mem_write_en_mask  out  N_TAG_BANKS*N_WAYS  per-bank way mask
tag_mem_address  out  N_TAG_BANKS*SET_PER_BANK_W  per-bank address
tag_mem_data_in  out  N_TAG_BANKS*N_WAYS*TAG_PER_WAY_DATA_W  per-bank write data
tag_mem_data_out  in  N_TAG_BANKS*N_WAYS*TAG_PER_WAY_DATA_W  per-bank read data; valid the cycle after a read enable

Behaviour:
- Reset values: FSM=INIT, init counter=0, init_done=0, rsp_valid=0, all rsp_* registers 0, s1_valid=0.
- FSM INIT: each cycle, all banks get chip_en=1, write_en=1, mask all ones, data_in=0, address=init counter. The counter increments each cycle. At count SET_PER_BANK-1 the FSM moves to RUN. init_done=1 from the next cycle, so INIT lasts exactly SET_PER_BANK cycles.
- RUN: fire = req_valid & req_ready. Memory outputs are combinational from the request.
  - Only the selected bank slice is driven: chip_en=1, write_en=req_write, mask=req_way_mask on writes and all ones on reads, address and data as the request.
  - Non-selected slices drive all-zero.
  - With no fire, all memory outputs are 0.
- Write: no response is produced. A write with an all-zero mask still asserts chip_en and write_en.
- Lookup pipeline:
  - Cycle T: fire and read issued. s1 captures bank, set and tag.
  - T+1: data_out slice of the s1 bank is sampled. The way compare is combinational, and the results are registered.
  - T+2: rsp_valid=1 for one cycle.
  - Throughput is one per cycle, responses in order. There is no backpressure; the consumer must accept.
- Compare: way i matches if entry[MSB]=1 and entry[TAG_W-1:0]==tag. rsp_hit = OR of matches. rsp_multi_hit = popcount>1.
- Ordering:
  - Read at T followed by a write to the same set at T+1: the read returns the old data.
  - Write at T followed by a read at T+1: the read returns the new data, because the memory has committed it.
- Requests presented during INIT are not accepted (req_ready=0) and are ignored.
- Reset mid-operation: in-flight lookups are dropped (no rsp_valid), and INIT restarts from address 0.

Decomposition:
- Package ccp_tag_pkg: state enum {INIT, RUN}; helper functions for bank/address split of a set; way-entry valid/tag field extraction.
- Sub-module ccp_tag_way_cmp: combinational N_WAYS compare producing way_oh, hit and multi_hit.

Test Plan:
- Reset release (defaults) -> init_done rises exactly 512 cycles later. Every address 0..511 is written on both banks with mask 2'b11 and data 0. req_ready=0 until then.
- Write set 5 (bank 1, addr 2), mask 2'b10, way1 = valid|tag 0x123 -> only bank 1 enabled, mask slice 2'b10. Then lookup set 5, tag 0x123 -> 2 cycles later rsp_hit=1, way_oh=2'b10, multi_hit=0, rsp_set=5.
- Lookup set 4 (bank 0, addr 2), tag 0x123 -> rsp_hit=0, way_oh=2'b00. Entry with tag 0x123 but valid=0 -> miss.
- Write both ways of set 7 with valid tag 0x55, then lookup 0x55 -> way_oh=2'b11, rsp_multi_hit=1.
- Back-to-back lookups on sets 0,1,2,3 in consecutive cycles -> rsp_valid high 4 consecutive cycles, rsp_set 0,1,2,3 in order. Chip_en alternates banks 2'b01, 2'b10.
- Assert reset_n low the cycle after a lookup fires -> no rsp_valid. After release, INIT restarts at address 0 and init_done=0 for 512 cycles.

Source files
------------

// File: rtl/ccp_tag_pkg.sv
// ----------------------------------------------------------------------------
// ccp_tag_pkg
// Shared configuration, types and helpers for the banked CCP tag memory
// controller.
//   - Geometry localparams (sets, banks, ways, entry width) and derived widths
//   - ctrl_state_e : controller state (clear sweep / normal operation)
//   - set_bank / set_addr : split a global set index into bank and bank address
//   - entry_valid / entry_tag : field extraction from one way entry
// ----------------------------------------------------------------------------
package ccp_tag_pkg;

    localparam int N_SETS             = 1024;
    localparam int N_TAG_BANKS        = 2;
    localparam int N_WAYS             = 2;
    localparam int TAG_PER_WAY_DATA_W = 25;

    localparam int SET_W          = $clog2(N_SETS);
    localparam int BNK_W          = $clog2(N_TAG_BANKS);
    // Bank index vectors need at least one bit even with a single bank
    localparam int BNK_IDX_W      = (BNK_W > 0) ? BNK_W : 1;
    localparam int SET_PER_BANK   = N_SETS / N_TAG_BANKS;
    localparam int SET_PER_BANK_W = $clog2(SET_PER_BANK);
    localparam int TAG_W          = TAG_PER_WAY_DATA_W - 1;
    localparam int SET_DATA_W     = N_WAYS * TAG_PER_WAY_DATA_W;
    localparam int WAY_CNT_W      = $clog2(N_WAYS + 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

    // Low set bits pick the bank so consecutive sets land in different banks
    function automatic logic [BNK_IDX_W-1:0] set_bank(input logic [SET_W-1:0] set_idx);
        return BNK_IDX_W'(set_idx % N_TAG_BANKS);
    endfunction

    // Remaining upper set bits address the set inside its bank
    function automatic logic [SET_PER_BANK_W-1:0] set_addr(input logic [SET_W-1:0] set_idx);
        return SET_PER_BANK_W'(set_idx >> BNK_W);
    endfunction

    function automatic logic entry_valid(input logic [TAG_PER_WAY_DATA_W-1:0] entry);
        return entry[TAG_PER_WAY_DATA_W-1];
    endfunction

    function automatic logic [TAG_W-1:0] entry_tag(input logic [TAG_PER_WAY_DATA_W-1:0] entry);
        return entry[TAG_W-1:0];
    endfunction

endpackage

// File: rtl/ccp_tag_way_cmp.sv
// ----------------------------------------------------------------------------
// ccp_tag_way_cmp
// Combinational tag compare across all ways of one set.
//   set_data  : raw set contents, way i at slice i
//   tag       : lookup tag
//   way_oh    : per-way match (valid and tag equal)
//   hit       : any way matched
//   multi_hit : more than one way matched (tag array corruption)
// ----------------------------------------------------------------------------
module ccp_tag_way_cmp
    import ccp_tag_pkg::*;
(
    input  logic [SET_DATA_W-1:0] set_data,
    input  logic [TAG_W-1:0]      tag,
    output logic [N_WAYS-1:0]     way_oh,
    output logic                  hit,
    output logic                  multi_hit
);

    logic [TAG_PER_WAY_DATA_W-1:0] entry_s;
    logic [WAY_CNT_W-1:0]          match_cnt_s;

    // Per-way match vector and match population count
    always_comb begin
        way_oh      = '0;
        entry_s     = '0;
        match_cnt_s = '0;
        for (int i = 0; i < N_WAYS; i++) begin
            entry_s = set_data[i*TAG_PER_WAY_DATA_W +: TAG_PER_WAY_DATA_W];
            if (entry_valid(entry_s) && (entry_tag(entry_s) == tag)) begin
                way_oh[i] = 1'b1;
            end else begin
                way_oh[i] = 1'b0;
            end
            match_cnt_s = match_cnt_s + WAY_CNT_W'(way_oh[i]);
        end
        hit       = |way_oh;
        multi_hit = (match_cnt_s > WAY_CNT_W'(1));
    end

endmodule

// File: rtl/ccp_tag_bank_ctrl.sv
// ----------------------------------------------------------------------------
// ccp_tag_bank_ctrl
// Controller for the banked CCP tag SRAM. After reset it clears every set of
// every bank, then accepts one lookup or write per cycle. Lookups return a
// registered response two cycles after they fire.
//   clk, reset_n       : clock, asynchronous active-low reset
//   init_done/req_ready: high once the clear sweep has finished
//   req_*              : request (write or lookup) with set, tag, mask, data
//   rsp_*              : lookup result (valid pulse, set, hit, way vector,
//                        multi-hit error, raw set data)
//   tag_mem_*          : per-bank SRAM interface; data_out is valid the cycle
//                        after a read enable
// ----------------------------------------------------------------------------
module ccp_tag_bank_ctrl
    import ccp_tag_pkg::*;
(
    input  logic                                           clk,
    input  logic                                           reset_n,
    output logic                                           init_done,
    input  logic                                           req_valid,
    output logic                                           req_ready,
    input  logic                                           req_write,
    input  logic [SET_W-1:0]                               req_set,
    input  logic [TAG_W-1:0]                               req_tag,
    input  logic [N_WAYS-1:0]                              req_way_mask,
    input  logic [SET_DATA_W-1:0]                          req_wdata,
    output logic                                           rsp_valid,
    output logic [SET_W-1:0]                               rsp_set,
    output logic                                           rsp_hit,
    output logic [N_WAYS-1:0]                              rsp_hit_way_oh,
    output logic                                           rsp_multi_hit,
    output logic [SET_DATA_W-1:0]                          rsp_rdata,
    output logic [N_TAG_BANKS-1:0]                         tag_mem_chip_en,
    output logic [N_TAG_BANKS-1:0]                         tag_mem_write_en,
    output logic [N_TAG_BANKS*N_WAYS-1:0]                  tag_mem_write_en_mask,
    output logic [N_TAG_BANKS*SET_PER_BANK_W-1:0]          tag_mem_address,
    output logic [N_TAG_BANKS*SET_DATA_W-1:0]              tag_mem_data_in,
    input  logic [N_TAG_BANKS*SET_DATA_W-1:0]              tag_mem_data_out
);

    ctrl_state_e               state_r;
    ctrl_state_e               state_nxt_s;
    logic [SET_PER_BANK_W-1:0] init_cnt_r;
    logic [SET_PER_BANK_W-1:0] init_cnt_nxt_s;
    logic                      init_done_r;

    logic                      fire_s;
    logic                      rd_fire_s;
    logic [BNK_IDX_W-1:0]      req_bank_s;
    logic [SET_PER_BANK_W-1:0] req_addr_s;

    logic                      s1_valid_r;
    logic [BNK_IDX_W-1:0]      s1_bank_r;
    logic [SET_W-1:0]          s1_set_r;
    logic [TAG_W-1:0]          s1_tag_r;

    logic [SET_DATA_W-1:0]     rd_data_s;
    logic [N_WAYS-1:0]         cmp_way_oh_s;
    logic                      cmp_hit_s;
    logic                      cmp_multi_s;

    logic                      rsp_valid_r;
    logic [SET_W-1:0]          rsp_set_r;
    logic                      rsp_hit_r;
    logic [N_WAYS-1:0]         rsp_way_oh_r;
    logic                      rsp_multi_r;
    logic [SET_DATA_W-1:0]     rsp_rdata_r;

    assign fire_s     = req_valid & init_done_r;
    assign rd_fire_s  = fire_s & ~req_write;
    assign req_bank_s = set_bank(req_set);
    assign req_addr_s = set_addr(req_set);

    // State, clear-sweep counter and init_done registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_INIT;
            init_cnt_r  <= '0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            init_cnt_r  <= init_cnt_nxt_s;
            init_done_r <= (state_nxt_s == ST_RUN);
        end
    end

    // Next state: sweep every bank address once, then run forever
    always_comb begin
        state_nxt_s    = state_r;
        init_cnt_nxt_s = init_cnt_r;
        case (state_r)
            ST_INIT: begin
                init_cnt_nxt_s = init_cnt_r + SET_PER_BANK_W'(1);
                if (init_cnt_r == SET_PER_BANK_W'(SET_PER_BANK - 1)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s    = ST_INIT;
                init_cnt_nxt_s = '0;
            end
        endcase
    end

    // SRAM drive: clear all banks during the sweep, else only the request's bank
    always_comb begin
        tag_mem_chip_en       = '0;
        tag_mem_write_en      = '0;
        tag_mem_write_en_mask = '0;
        tag_mem_address       = '0;
        tag_mem_data_in       = '0;
        case (state_r)
            ST_INIT: begin
                for (int b = 0; b < N_TAG_BANKS; b++) begin
                    tag_mem_chip_en[b]                                  = 1'b1;
                    tag_mem_write_en[b]                                 = 1'b1;
                    tag_mem_write_en_mask[b*N_WAYS +: N_WAYS]           = '1;
                    tag_mem_address[b*SET_PER_BANK_W +: SET_PER_BANK_W] = init_cnt_r;
                end
            end
            ST_RUN: begin
                if (fire_s) begin
                    for (int b = 0; b < N_TAG_BANKS; b++) begin
                        if (BNK_IDX_W'(b) == req_bank_s) begin
                            tag_mem_chip_en[b]  = 1'b1;
                            tag_mem_write_en[b] = req_write;
                            // Reads fetch the whole set regardless of the request mask
                            if (req_write) begin
                                tag_mem_write_en_mask[b*N_WAYS +: N_WAYS] = req_way_mask;
                            end else begin
                                tag_mem_write_en_mask[b*N_WAYS +: N_WAYS] = '1;
                            end
                            tag_mem_address[b*SET_PER_BANK_W +: SET_PER_BANK_W] = req_addr_s;
                            tag_mem_data_in[b*SET_DATA_W +: SET_DATA_W]         = req_wdata;
                        end else begin
                            tag_mem_chip_en[b] = 1'b0;
                        end
                    end
                end else begin
                    tag_mem_chip_en = '0;
                end
            end
            default: begin
                tag_mem_chip_en = '0;
            end
        endcase
    end

    // Stage 1: remember which bank/set/tag the outstanding read belongs to
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            s1_bank_r  <= '0;
            s1_set_r   <= '0;
            s1_tag_r   <= '0;
        end else begin
            s1_valid_r <= rd_fire_s;
            if (rd_fire_s) begin
                s1_bank_r <= req_bank_s;
                s1_set_r  <= req_set;
                s1_tag_r  <= req_tag;
            end
        end
    end

    assign rd_data_s = tag_mem_data_out[int'(s1_bank_r)*SET_DATA_W +: SET_DATA_W];

    ccp_tag_way_cmp u_way_cmp (
        .set_data  (rd_data_s),
        .tag       (s1_tag_r),
        .way_oh    (cmp_way_oh_s),
        .hit       (cmp_hit_s),
        .multi_hit (cmp_multi_s)
    );

    // Stage 2: register the compare result as the response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_r  <= 1'b0;
            rsp_set_r    <= '0;
            rsp_hit_r    <= 1'b0;
            rsp_way_oh_r <= '0;
            rsp_multi_r  <= 1'b0;
            rsp_rdata_r  <= '0;
        end else begin
            rsp_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                rsp_set_r    <= s1_set_r;
                rsp_hit_r    <= cmp_hit_s;
                rsp_way_oh_r <= cmp_way_oh_s;
                rsp_multi_r  <= cmp_multi_s;
                rsp_rdata_r  <= rd_data_s;
            end
        end
    end

    assign init_done      = init_done_r;
    assign req_ready      = init_done_r;
    assign rsp_valid      = rsp_valid_r;
    assign rsp_set        = rsp_set_r;
    assign rsp_hit        = rsp_hit_r;
    assign rsp_hit_way_oh = rsp_way_oh_r;
    assign rsp_multi_hit  = rsp_multi_r;
    assign rsp_rdata      = rsp_rdata_r;

endmodule

// File: tb/tb_ccp_tag_bank_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ccp_tag_bank_ctrl
// Directed bench for ccp_tag_bank_ctrl with a behavioural two-bank tag SRAM.
// Lookups push their expected response into a queue; a monitor pops and
// compares whenever rsp_valid is seen.
// ----------------------------------------------------------------------------
module tb_ccp_tag_bank_ctrl;
    import ccp_tag_pkg::*;

    logic                                  clk;
    logic                                  reset_n;
    logic                                  init_done;
    logic                                  req_valid;
    logic                                  req_ready;
    logic                                  req_write;
    logic [SET_W-1:0]                      req_set;
    logic [TAG_W-1:0]                      req_tag;
    logic [N_WAYS-1:0]                     req_way_mask;
    logic [SET_DATA_W-1:0]                 req_wdata;
    logic                                  rsp_valid;
    logic [SET_W-1:0]                      rsp_set;
    logic                                  rsp_hit;
    logic [N_WAYS-1:0]                     rsp_hit_way_oh;
    logic                                  rsp_multi_hit;
    logic [SET_DATA_W-1:0]                 rsp_rdata;
    logic [N_TAG_BANKS-1:0]                tag_mem_chip_en;
    logic [N_TAG_BANKS-1:0]                tag_mem_write_en;
    logic [N_TAG_BANKS*N_WAYS-1:0]         tag_mem_write_en_mask;
    logic [N_TAG_BANKS*SET_PER_BANK_W-1:0] tag_mem_address;
    logic [N_TAG_BANKS*SET_DATA_W-1:0]     tag_mem_data_in;
    logic [N_TAG_BANKS*SET_DATA_W-1:0]     tag_mem_data_out;

    ccp_tag_bank_ctrl dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .init_done             (init_done),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_write             (req_write),
        .req_set               (req_set),
        .req_tag               (req_tag),
        .req_way_mask          (req_way_mask),
        .req_wdata             (req_wdata),
        .rsp_valid             (rsp_valid),
        .rsp_set               (rsp_set),
        .rsp_hit               (rsp_hit),
        .rsp_hit_way_oh        (rsp_hit_way_oh),
        .rsp_multi_hit         (rsp_multi_hit),
        .rsp_rdata             (rsp_rdata),
        .tag_mem_chip_en       (tag_mem_chip_en),
        .tag_mem_write_en      (tag_mem_write_en),
        .tag_mem_write_en_mask (tag_mem_write_en_mask),
        .tag_mem_address       (tag_mem_address),
        .tag_mem_data_in       (tag_mem_data_in),
        .tag_mem_data_out      (tag_mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural tag SRAM ----------------
    logic [SET_DATA_W-1:0] mem [N_TAG_BANKS][SET_PER_BANK];
    logic                  fill_req;

    // Synchronous SRAM: masked per-way write, registered read; fill_req
    // preloads valid entries so a missing clear sweep shows up as hits
    always @(posedge clk) begin
        if (fill_req) begin
            for (int b = 0; b < N_TAG_BANKS; b++)
                for (int a = 0; a < SET_PER_BANK; a++)
                    mem[b][a] <= {1'b1, 24'h0, 1'b1, 24'h0};
        end else begin
            for (int b = 0; b < N_TAG_BANKS; b++) begin
                if (tag_mem_chip_en[b]) begin
                    if (tag_mem_write_en[b]) begin
                        for (int w = 0; w < N_WAYS; w++)
                            if (tag_mem_write_en_mask[b*N_WAYS+w])
                                mem[b][tag_mem_address[b*SET_PER_BANK_W +: SET_PER_BANK_W]][w*TAG_PER_WAY_DATA_W +: TAG_PER_WAY_DATA_W]
                                    <= tag_mem_data_in[b*SET_DATA_W + w*TAG_PER_WAY_DATA_W +: TAG_PER_WAY_DATA_W];
                    end else begin
                        tag_mem_data_out[b*SET_DATA_W +: SET_DATA_W]
                            <= mem[b][tag_mem_address[b*SET_PER_BANK_W +: SET_PER_BANK_W]];
                    end
                end
            end
        end
    end

    // ---------------- checking infrastructure ----------------
    int n_checks;
    int n_pass;
    int cur_run;
    int last_run;

    typedef struct {
        logic [SET_W-1:0]      set;
        logic                  hit;
        logic [N_WAYS-1:0]     oh;
        logic                  multi;
        logic [SET_DATA_W-1:0] rdata;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [TAG_PER_WAY_DATA_W-1:0] ent(input logic v, input logic [TAG_W-1:0] t);
        return {v, t};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_rsp(input logic [SET_W-1:0] s, input logic h, input logic [N_WAYS-1:0] oh,
                              input logic m, input logic [SET_DATA_W-1:0] rd);
        exp_t e;
        e.set = s; e.hit = h; e.oh = oh; e.multi = m; e.rdata = rd;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every response against the oldest expectation
    initial begin
        exp_t e;
        cur_run  = 0;
        last_run = 0;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                cur_run++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 set=%0d expected no response", rsp_set);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_set", rsp_set, e.set);
                    chk("rsp_hit", rsp_hit, e.hit);
                    chk("rsp_way_oh", rsp_hit_way_oh, e.oh);
                    chk("rsp_multi_hit", rsp_multi_hit, e.multi);
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                end
            end else begin
                if (cur_run != 0) last_run = cur_run;
                cur_run = 0;
            end
        end
    end

    // Drive one request for one cycle and check the combinational SRAM drive
    task automatic issue(input logic wr, input logic [SET_W-1:0] s, input logic [TAG_W-1:0] t,
                         input logic [N_WAYS-1:0] m, input logic [SET_DATA_W-1:0] wd,
                         input logic [1:0] e_ce, input logic [3:0] e_mask, input logic [17:0] e_addr);
        req_valid    = 1'b1;
        req_write    = wr;
        req_set      = s;
        req_tag      = t;
        req_way_mask = m;
        req_wdata    = wd;
        #1;
        chk("chip_en", tag_mem_chip_en, e_ce);
        chk("write_en", tag_mem_write_en, wr ? e_ce : 2'b00);
        chk("write_mask", tag_mem_write_en_mask, e_mask);
        chk("address", tag_mem_address, e_addr);
        @(negedge clk);
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_way_mask = '0;
        req_wdata    = '0;
    endtask

    // Reset, then follow the clear sweep cycle by cycle
    task automatic run_init();
        int bad;
        bad = 0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_init_done", init_done, 1'b0);
        chk("reset_rsp_fields", {rsp_set, rsp_hit, rsp_hit_way_oh, rsp_multi_hit}, 14'h0);
        // A request offered during the sweep must be ignored
        req_valid = 1'b1;
        req_write = 1'b0;
        req_set   = 10'd3;
        reset_n   = 1'b1;
        for (int k = 0; k < SET_PER_BANK; k++) begin
            #1;
            if (k == 0) chk("init_first_addr", tag_mem_address, 18'h0);
            if (init_done !== 1'b0 || req_ready !== 1'b0 || tag_mem_chip_en !== 2'b11 ||
                tag_mem_write_en !== 2'b11 || tag_mem_write_en_mask !== 4'hF ||
                tag_mem_data_in !== '0 || tag_mem_address !== {9'(k), 9'(k)})
                bad++;
            if (k == 500) req_valid = 1'b0;
            @(negedge clk);
        end
        #1;
        chk("init_sweep_bad_cycles", bad, 0);
        chk("init_done_after_512", init_done, 1'b1);
        chk("req_ready_after_512", req_ready, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n      = 1'b0;
        fill_req     = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_set      = '0;
        req_tag      = '0;
        req_way_mask = '0;
        req_wdata    = '0;
        n_checks     = 0;
        n_pass       = 0;
        @(negedge clk);
        fill_req = 1'b0;

        run_init();

        // Idle: nothing driven to the SRAM
        chk("idle_chip_en", tag_mem_chip_en, 2'b00);

        // Write set 5 way1 only; way0 data must be masked off
        req_valid = 1'b1; req_write = 1'b1; req_set = 10'd5; req_way_mask = 2'b10;
        req_wdata = {ent(1'b1, 24'h123), 25'h1ABCDEF};
        #1;
        chk("wr5_data_in", tag_mem_data_in, {ent(1'b1, 24'h123), 25'h1ABCDEF, 50'h0});
        issue(1'b1, 10'd5, 24'h0, 2'b10, {ent(1'b1, 24'h123), 25'h1ABCDEF}, 2'b10, 4'b1000, {9'd2, 9'd0});
        issue(1'b0, 10'd5, 24'h123, 2'b00, '0, 2'b10, 4'b1100, {9'd2, 9'd0});
        expect_rsp(10'd5, 1'b1, 2'b10, 1'b0, {ent(1'b1, 24'h123), 25'h0});
        issue(1'b0, 10'd4, 24'h123, 2'b00, '0, 2'b01, 4'b0011, {9'd0, 9'd2});
        expect_rsp(10'd4, 1'b0, 2'b00, 1'b0, 50'h0);

        // Set 9: way0 has the tag but is invalid, way1 valid with another tag
        issue(1'b1, 10'd9, 24'h0, 2'b11, {ent(1'b1, 24'h124), ent(1'b0, 24'h123)}, 2'b10, 4'b1100, {9'd4, 9'd0});
        issue(1'b0, 10'd9, 24'h123, 2'b00, '0, 2'b10, 4'b1100, {9'd4, 9'd0});
        expect_rsp(10'd9, 1'b0, 2'b00, 1'b0, {ent(1'b1, 24'h124), ent(1'b0, 24'h123)});

        // Set 7: both ways hold the same valid tag
        issue(1'b1, 10'd7, 24'h0, 2'b11, {ent(1'b1, 24'h55), ent(1'b1, 24'h55)}, 2'b10, 4'b1100, {9'd3, 9'd0});
        issue(1'b0, 10'd7, 24'h55, 2'b00, '0, 2'b10, 4'b1100, {9'd3, 9'd0});
        expect_rsp(10'd7, 1'b1, 2'b11, 1'b1, {ent(1'b1, 24'h55), ent(1'b1, 24'h55)});

        // Zero-mask write still enables the bank and asserts write
        issue(1'b1, 10'd6, 24'h0, 2'b00, {ent(1'b1, 24'h77), ent(1'b1, 24'h77)}, 2'b01, 4'b0000, {9'd0, 9'd3});
        repeat (3) @(negedge clk);

        // Back-to-back lookups of cleared sets 0..3 (tag 0, all entries invalid)
        issue(1'b0, 10'd0, 24'h0, 2'b00, '0, 2'b01, 4'b0011, {9'd0, 9'd0});
        expect_rsp(10'd0, 1'b0, 2'b00, 1'b0, 50'h0);
        issue(1'b0, 10'd1, 24'h0, 2'b00, '0, 2'b10, 4'b1100, {9'd0, 9'd0});
        expect_rsp(10'd1, 1'b0, 2'b00, 1'b0, 50'h0);
        issue(1'b0, 10'd2, 24'h0, 2'b00, '0, 2'b01, 4'b0011, {9'd0, 9'd1});
        expect_rsp(10'd2, 1'b0, 2'b00, 1'b0, 50'h0);
        issue(1'b0, 10'd3, 24'h0, 2'b00, '0, 2'b10, 4'b1100, {9'd1, 9'd0});
        expect_rsp(10'd3, 1'b0, 2'b00, 1'b0, 50'h0);
        repeat (5) @(negedge clk);
        chk("b2b_rsp_run_length", last_run, 4);

        // Read then write same set: old data; write then read: new data
        issue(1'b0, 10'd5, 24'h123, 2'b00, '0, 2'b10, 4'b1100, {9'd2, 9'd0});
        expect_rsp(10'd5, 1'b1, 2'b10, 1'b0, {ent(1'b1, 24'h123), 25'h0});
        issue(1'b1, 10'd5, 24'h0, 2'b10, {ent(1'b1, 24'h200), 25'h0}, 2'b10, 4'b1000, {9'd2, 9'd0});
        issue(1'b0, 10'd5, 24'h200, 2'b00, '0, 2'b10, 4'b1100, {9'd2, 9'd0});
        expect_rsp(10'd5, 1'b1, 2'b10, 1'b0, {ent(1'b1, 24'h200), 25'h0});
        repeat (4) @(negedge clk);
        chk("sb_drained_before_reset", sb_q.size(), 0);

        // Lookup fires, reset the next cycle: no response may appear
        issue(1'b0, 10'd7, 24'h55, 2'b00, '0, 2'b10, 4'b1100, {9'd3, 9'd0});
        run_init();
        repeat (4) @(negedge clk);
        chk("sb_drained_final", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
